// File: rtl/serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// serial_nibble_adder
//
// Purpose:
//   Sequential wide-word adder controller. It wraps an external 4-bit adder
//   (adder_4bit) that is connected between the add_* ports. A WIDTH-bit
//   addition is done one nibble per clock, least-significant nibble first.
//   Each nibble sum and the ripple carry are registered between steps.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand word valid
//   in_ready   out  block can accept operands (IDLE only)
//   in_a/in_b  in   WIDTH-bit operands
//   in_cin     in   carry-in
//   add_a      out  nibble of A to adder_4bit a
//   add_b      out  nibble of B to adder_4bit b
//   add_cin    out  registered carry to adder_4bit c
//   add_sum    in   adder_4bit sum (combinational from add_*)
//   add_cout   in   adder_4bit carry-out
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   out_sum    out  WIDTH-bit sum
//   out_cout   out  final carry-out
//   busy       out  high in RUN or DONE
// ---------------------------------------------------------------------------
module serial_nibble_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    // Number of nibble steps; derived, not a user parameter.
    localparam int NIB = WIDTH / 4;
    // Nibble index width, at least one bit so a single-nibble build still
    // has a legal register.
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("serial_nibble_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [KW-1:0]    k_reg;

    logic [3:0]       a_nib   [NIB];
    logic [3:0]       b_nib   [NIB];
    logic [3:0]       sum_nib [NIB];
    logic [WIDTH-1:0] sum_flat;

    logic accept;
    logic in_run;
    logic last_step;

    assign accept    = (state_reg == S_IDLE) && in_valid;
    assign in_run    = (state_reg == S_RUN);
    assign last_step = (k_reg == K_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic
    // The adder is only fed from registers, so there is no combinational
    // path from in_* to add_*. Outside RUN the adder inputs are held at 0.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_nib[k_reg];
                add_b   = b_nib[k_reg];
                add_cin = carry_reg;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = sum_flat;
                out_cout  = carry_reg;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand, carry and nibble-index registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            k_reg     <= '0;
        end else if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            k_reg     <= '0;
        end else if (in_run) begin
            carry_reg <= add_cout;
            // k parks at the last index; the next accept clears it.
            if (!last_step) begin
                k_reg <= k_reg + KW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-nibble views of the operands and per-nibble sum registers.
    // Each sum nibble has its own register so only the nibble addressed by
    // k is written on a given RUN cycle.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];

            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_nib[gi] <= 4'd0;
                end else if (accept) begin
                    sum_nib[gi] <= 4'd0;
                end else if (in_run && (k_reg == KW'(gi))) begin
                    sum_nib[gi] <= add_sum;
                end
            end

            assign sum_flat[4*gi +: 4] = sum_nib[gi];
        end
    endgenerate

endmodule

// File: tb/tb_serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_nibble_adder
//
// Self-checking bench for serial_nibble_adder (WIDTH=16). A behavioural
// 4-bit adder sits between the add_* ports. Table-driven transactions check
// nibble sequencing, carry ripple and latency; hand-written sequences cover
// backpressure, reset in the middle of RUN and back-to-back throughput.
// ---------------------------------------------------------------------------
module tb_serial_nibble_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    int n_cmp;
    int n_fail;
    int cyc;

    serial_nibble_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Behavioural stand-in for adder_4bit.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic [3:0]  exp_cins;   // bit k = expected add_cin on RUN step k
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full transaction from IDLE: accept, NIB RUN steps, DONE, handoff.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [15:0] exp_sum, input logic exp_cout,
                           input logic [3:0] exp_cins);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1'b1);
        step();
        // Scramble inputs during RUN; they must be ignored.
        in_a   = ~a;
        in_b   = ~b;
        in_cin = ~cin;
        for (int k = 0; k < NIB; k++) begin
            chk("run_add_a",   add_a,   a[4*k +: 4]);
            chk("run_add_b",   add_b,   b[4*k +: 4]);
            chk("run_add_cin", add_cin, exp_cins[k]);
            chk("run_busy",    busy,    1'b1);
            chk("run_in_ready", in_ready, 1'b0);
            chk("run_out_valid", out_valid, 1'b0);
            step();
        end
        chk("done_out_valid", out_valid, 1'b1);
        chk("done_out_sum",   out_sum,   exp_sum);
        chk("done_out_cout",  out_cout,  exp_cout);
        chk("done_add_a",     add_a,     4'd0);
        $display("txn a=%h b=%h cin=%0d -> sum=%h cout=%0d (exp %h %0d)",
                 a, b, cin, out_sum, out_cout, exp_sum, exp_cout);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("handoff_out_valid", out_valid, 1'b0);
        chk("handoff_in_ready",  in_ready,  1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [16:0] exp_r [20];
        logic [15:0] ra    [20];
        logic [15:0] rb    [20];
        logic        rc    [20];
        int          prev_cyc;
        bit          timed_out;

        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 4'b0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 4'b0001};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b1111};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'b0001};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 4'b1110};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 4'b1110};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 4'b0000};

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_out_sum",   out_sum,   16'h0000);
        chk("rst_out_cout",  out_cout,  1'b0);
        chk("rst_add",       {add_a, add_b, add_cin}, 9'd0);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_cins);
        end

        // Backpressure: 0x8000+0x8000 held in DONE with new operands offered
        in_a = 16'h8000;
        in_b = 16'h8000;
        in_cin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_a = 16'h1111;
        in_b = 16'h2222;
        for (int k = 0; k < NIB; k++) begin
            step();
        end
        for (int h = 0; h < 3; h++) begin
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_sum",   out_sum,   16'h0000);
            chk("bp_out_cout",  out_cout,  1'b1);
            chk("bp_in_ready",  in_ready,  1'b0);
            chk("bp_add_a",     add_a,     4'd0);
            step();
        end
        chk("bp_still_valid", out_valid, 1'b1);
        $display("txn a=8000 b=8000 cin=0 held -> sum=%h cout=%0d (exp 0000 1)", out_sum, out_cout);
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready,  1'b1);
        out_ready = 1'b0;
        step();
        chk("bp_next_accept_busy", busy,  1'b1);
        chk("bp_next_add_a",       add_a, 4'h1);
        chk("bp_next_add_b",       add_b, 4'h2);
        in_valid = 1'b0;
        for (int k = 0; k < NIB; k++) begin
            step();
        end
        chk("bp_next_sum",  out_sum,  16'h3333);
        chk("bp_next_cout", out_cout, 1'b0);
        $display("txn a=1111 b=2222 cin=0 -> sum=%h cout=%0d (exp 3333 0)", out_sum, out_cout);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_final_idle", in_ready, 1'b1);

        // Reset in the middle of RUN (at k=2)
        in_a = 16'hAAAA;
        in_b = 16'h5555;
        in_cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_k2_add_a", add_a, 4'hA);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready",  in_ready,  1'b1);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy",      busy,      1'b0);
        chk("mid_rst_out_sum",   out_sum,   16'h0000);
        chk("mid_rst_add_cin",   add_cin,   1'b0);
        begin
            logic seen;
            seen = 1'b0;
            for (int w = 0; w < 6; w++) begin
                step();
                seen = seen | out_valid;
            end
            chk("mid_rst_no_valid", seen, 1'b0);
        end
        $display("txn a=aaaa b=5555 dropped by reset");
        run_txn(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 4'b1110);

        // Back-to-back random operands with in_valid and out_ready held high
        for (int i = 0; i < 20; i++) begin
            ra[i] = 16'($urandom());
            rb[i] = 16'($urandom());
            rc[i] = 1'($urandom_range(0, 1));
            exp_r[i] = {1'b0, ra[i]} + {1'b0, rb[i]} + 17'(rc[i]);
        end
        in_a = ra[0];
        in_b = rb[0];
        in_cin = rc[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        prev_cyc = 0;
        timed_out = 1'b0;
        for (int i = 0; i < 20 && !timed_out; i++) begin
            for (int w = 0; w < 20 && !out_valid; w++) begin
                step();
            end
            if (!out_valid) begin
                chk("b2b_timeout", 32'd0, 32'd1);
                timed_out = 1'b1;
            end else begin
                chk("b2b_result", {out_cout, out_sum}, exp_r[i]);
                if (i > 0) begin
                    chk("b2b_interval", cyc - prev_cyc, NIB + 2);
                end
                $display("txn b2b a=%h b=%h cin=%0d -> %h (exp %h) cycle %0d",
                         ra[i], rb[i], rc[i], {out_cout, out_sum}, exp_r[i], cyc);
                prev_cyc = cyc;
                if (i < 19) begin
                    in_a = ra[i+1];
                    in_b = rb[i+1];
                    in_cin = rc[i+1];
                end else begin
                    in_valid = 1'b0;
                end
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_nibble_adder.md
Name: serial_nibble_adder

Overview:
- Sequential wide-word adder controller that sits directly around the team's adder_4bit.
- Accepts WIDTH-bit operands plus carry-in through a valid/ready handshake.
- Feeds the 4-bit adder one nibble per clock, least-significant nibble first, and registers each nibble sum and the ripple carry.
- Presents the full WIDTH-bit sum and carry-out through a valid/ready output handshake. Bench and top level connect adder_4bit between the add_* ports.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIB (derived, not overridable), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- add_a  output  4  nibble of A driven to adder_4bit a.
- add_b  output  4  nibble of B driven to adder_4bit b.
- add_cin  output  1  carry driven to adder_4bit c.
- add_sum  input  4  adder_4bit sum, combinational from add_*.
- add_cout  input  1  adder_4bit cout.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  registered sum.
- out_cout  output  1  registered final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. While rst is high at a rising edge, the block goes to IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, add_a/add_b/add_cin=0. Internal operand registers, carry register and nibble index k are all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; add_* driven to 0.
  - On an edge with in_valid&&in_ready: capture in_a, in_b, in_cin (into the carry register); set k=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - add_a=a_reg[4k+3:4k], add_b=b_reg[4k+3:4k], add_cin=carry register.
  - Each edge: sum_reg[4k+3:4k]<=add_sum; carry<=add_cout; k<=k+1.
  - On the edge where k==NIB-1: go to DONE instead of incrementing.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_cout=carry; add_* driven to 0.
  - Outputs held stable while out_ready=0.
  - On an edge with out_valid&&out_ready: go to IDLE, out_valid drops.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (4 for WIDTH=16).
- Throughput: with in_valid and out_ready held high, one result every NIB+2 cycles. No overlap: in_ready=0 in RUN and DONE.
- in_valid, in_a, in_b and in_cin are ignored outside IDLE. Changing in_* during RUN does not affect the result.
- Arithmetic: {out_cout,out_sum} == in_a+in_b+in_cin, modulo 2^(WIDTH+1).
- Carry ripples across nibble boundaries only through the registered carry; there is no combinational path from in_* to add_*.
- Reset mid-operation (RUN or DONE): the transaction is dropped, no out_valid is produced, and all reset values apply on the next cycle.
- rst takes priority over any simultaneous handshake on the same edge.
- k is only $clog2(NIB) bits wide (minimum 1). It never wraps beyond NIB-1.

Test Plan:
- Reset, then in_a=0x0000, in_b=0x0001, cin=0 accepted at edge E0 -> out_valid high after E4, out_sum=0x0001, out_cout=0; add_cin=0 on all four RUN cycles.
- in_a=0xFFFF, in_b=0x0001, cin=0 -> out_sum=0x0000, out_cout=1; add_cin observed as 0,1,1,1 in RUN cycles k=0..3.
- in_a=0x1234, in_b=0x4321, cin=1 -> out_sum=0x5556, out_cout=0; add_a sequence 4,3,2,1 and add_b sequence 1,2,3,4.
- Backpressure: complete in_a=0x8000, in_b=0x8000, then hold out_ready=0 for 3 cycles with in_valid=1 and new operands -> out_sum=0x0000 and out_cout=1 held stable, in_ready=0, new operands not accepted. out_ready=1 -> IDLE, then the next operand is accepted on the following edge.
- Reset mid-RUN: assert rst at k=2 of 0xAAAA+0x5555 -> next cycle in_ready=1, out_valid=0, busy=0, out_sum=0. The following transaction 0x0F0F+0x00F1 gives out_sum=0x1000, out_cout=0.
- Back-to-back, 20 random operand pairs with in_valid and out_ready held high -> results match in_a+in_b+in_cin and arrive every 6 cycles for WIDTH=16.
